fg_timebase: RTL and testbench

Upstream timebase for the function-generator waveform stage. It generates the tick strobe and the period counter value that the waveform FSM consumes, using a programmable prescaler. Period and ON-count are double-buffered so that the waveform stage always sees a consistent pair. Shadow registers update only at period boundaries. A one-shot mode is also provided.

---
 rtl/fg_pkg.sv | 14 +
 rtl/fg_prescaler.sv | 31 +++
 rtl/fg_timebase.sv | 128 ++++++++++++
 tb/tb_fg_timebase.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fg_pkg.sv
// Shared definitions for the function-generator stages: default widths and
// the run-state encoding used by the timebase and downstream stages.
package fg_pkg;

  localparam int unsigned FG_COUNTER_BITWIDTH   = 32;
  localparam int unsigned FG_PRESCALER_BITWIDTH = 16;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } run_state_e;

endpackage

// File: rtl/fg_prescaler.sv
// Divide-by-(divide+1) tick generator with synchronous clear.
// tick is high in the cycle where the count equals divide and the
// prescaler is not being cleared.
module fg_prescaler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] divide,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q;

  assign tick = (cnt_q == divide) && !clear;

  // Count up to divide, then restart at 0; clear holds the count at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (cnt_q == divide) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fg_timebase.sv
// Timebase for the function-generator waveform stage: prescaled tick strobe,
// period counter, double-buffered period/ON-count/prescale shadows that
// reload only at period wraps, and an optional one-shot mode.
module fg_timebase
  import fg_pkg::*;
#(
  parameter int unsigned COUNTER_BITWIDTH   = FG_COUNTER_BITWIDTH,
  parameter int unsigned PRESCALER_BITWIDTH = FG_PRESCALER_BITWIDTH
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          enable_i,
  input  logic                          oneshot_i,
  input  logic                          update_i,
  input  logic [PRESCALER_BITWIDTH-1:0] prescale_i,
  input  logic [COUNTER_BITWIDTH-1:0]   period_i,
  input  logic [COUNTER_BITWIDTH-1:0]   on_count_i,
  output logic [COUNTER_BITWIDTH-1:0]   counter_value_o,
  output logic [COUNTER_BITWIDTH-1:0]   period_o,
  output logic [COUNTER_BITWIDTH-1:0]   on_count_o,
  output logic                          strb_data_valid_o,
  output logic                          wrap_o,
  output logic                          running_o,
  output logic                          done_o
);

  run_state_e                    state_q;
  logic [PRESCALER_BITWIDTH-1:0] prescale_q;
  logic                          pending_q;
  logic                          oneshot_q;
  logic                          run_en;
  logic                          tick;
  logic                          at_end;

  // Prescaler only runs while running and still enabled; any other cycle
  // (stopped, done, stop request, start) parks it at 0.
  assign run_en = (state_q == RUNNING) && enable_i;
  assign at_end = (counter_value_o == period_o);

  fg_prescaler #(
    .WIDTH (PRESCALER_BITWIDTH)
  ) u_prescaler (
    .clk    (clk_i),
    .rst_n  (rstn_i),
    .clear  (!run_en),
    .divide (prescale_q),
    .tick   (tick)
  );

  // Run control, counter advance, shadow reload and registered strobes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q           <= STOPPED;
      prescale_q        <= '0;
      pending_q         <= 1'b0;
      oneshot_q         <= 1'b0;
      counter_value_o   <= '0;
      period_o          <= '0;
      on_count_o        <= '0;
      strb_data_valid_o <= 1'b0;
      wrap_o            <= 1'b0;
      running_o         <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      strb_data_valid_o <= 1'b0;
      wrap_o            <= 1'b0;
      // Default: a request is remembered; a wrap or start below consumes it.
      if (update_i) pending_q <= 1'b1;

      case (state_q)
        STOPPED: begin
          if (enable_i) begin
            state_q           <= RUNNING;
            running_o         <= 1'b1;
            period_o          <= period_i;
            on_count_o        <= on_count_i;
            prescale_q        <= prescale_i;
            oneshot_q         <= oneshot_i;
            counter_value_o   <= '0;
            strb_data_valid_o <= 1'b1;
            wrap_o            <= 1'b1;
            pending_q         <= 1'b0;
          end
        end

        RUNNING: begin
          if (!enable_i) begin
            state_q         <= STOPPED;
            running_o       <= 1'b0;
            counter_value_o <= '0;
          end else if (tick) begin
            if (!at_end) begin
              counter_value_o   <= counter_value_o + COUNTER_BITWIDTH'(1);
              strb_data_valid_o <= 1'b1;
            end else if (!oneshot_q) begin
              counter_value_o   <= '0;
              strb_data_valid_o <= 1'b1;
              wrap_o            <= 1'b1;
              if (pending_q || update_i) begin
                period_o   <= period_i;
                on_count_o <= on_count_i;
                prescale_q <= prescale_i;
                pending_q  <= 1'b0;
              end
            end else begin
              state_q   <= DONE;
              running_o <= 1'b0;
              done_o    <= 1'b1;
            end
          end
        end

        DONE: begin
          if (!enable_i) begin
            state_q         <= STOPPED;
            done_o          <= 1'b0;
            counter_value_o <= '0;
          end
        end

        default: begin
          state_q <= STOPPED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fg_timebase.sv
// Self-checking bench for fg_timebase: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a behavioural model.
module tb_fg_timebase;

  localparam int unsigned CW = 32;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic          oneshot = 1'b0;
  logic          update = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [CW-1:0] period = '0;
  logic [CW-1:0] on_count = '0;
  logic [CW-1:0] counter_value, period_q, on_count_q;
  logic          strb, wrap, running, done;

  fg_timebase #(
    .COUNTER_BITWIDTH   (CW),
    .PRESCALER_BITWIDTH (PW)
  ) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .enable_i          (enable),
    .oneshot_i         (oneshot),
    .update_i          (update),
    .prescale_i        (prescale),
    .period_i          (period),
    .on_count_i        (on_count),
    .counter_value_o   (counter_value),
    .period_o          (period_q),
    .on_count_o        (on_count_q),
    .strb_data_valid_o (strb),
    .wrap_o            (wrap),
    .running_o         (running),
    .done_o            (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: observable state plus clocks-left-until-next-tick.
  bit          m_run, m_done, m_strb, m_wrap, m_pend, m_os;
  logic [CW-1:0] m_cnt, m_per, m_on;
  int          m_pre;
  int          m_left;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_strb = 0; m_wrap = 0; m_pend = 0; m_os = 0;
    m_cnt = '0; m_per = '0; m_on = '0; m_pre = 0; m_left = 0;
  endtask

  task automatic load_shadows();
    m_per = period;
    m_on  = on_count;
    m_pre = int'(prescale);
  endtask

  // One clock edge of the specified behaviour, using the inputs held before it.
  task automatic model_edge();
    m_strb = 0;
    m_wrap = 0;
    if (!m_run && !m_done) begin
      if (enable) begin
        load_shadows();
        m_os = oneshot; m_cnt = '0; m_run = 1;
        m_strb = 1; m_wrap = 1; m_pend = 0;
        m_left = m_pre + 1;
      end else if (update) begin
        m_pend = 1;
      end
    end else if (m_done) begin
      if (update) m_pend = 1;
      if (!enable) begin
        m_done = 0; m_cnt = '0;
      end
    end else if (!enable) begin
      if (update) m_pend = 1;
      m_run = 0; m_cnt = '0;
    end else if (m_left > 1) begin
      if (update) m_pend = 1;
      m_left--;
    end else begin
      if (m_cnt < m_per) begin
        if (update) m_pend = 1;
        m_cnt++; m_strb = 1;
        m_left = m_pre + 1;
      end else if (!m_os) begin
        m_cnt = '0; m_strb = 1; m_wrap = 1;
        if (m_pend || update) begin
          load_shadows();
          m_pend = 0;
        end
        m_left = m_pre + 1;
      end else begin
        if (update) m_pend = 1;
        m_run = 0; m_done = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("counter",  counter_value, m_cnt);
    check("period",   period_q,      m_per);
    check("on_count", on_count_q,    m_on);
    check("strb",     CW'(strb),     CW'(m_strb));
    check("wrap",     CW'(wrap),     CW'(m_wrap));
    check("running",  CW'(running),  CW'(m_run));
    check("done",     CW'(done),     CW'(m_done));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    rstn = 1'b1;
    step();

    // Free run: prescale 2, period 4.
    prescale = 16'd2; period = 32'd4; on_count = 32'd1; enable = 1'b1;
    steps(20);

    // Shadow update mid-period: period 4 -> 2 at the next wrap.
    for (int i = 0; i < 40 && !(m_strb && m_cnt == 1); i++) step();
    check("wait_cnt1", CW'(m_strb && m_cnt == 1), CW'(1));
    period = 32'd2; update = 1'b1;
    step();
    update = 1'b0;
    check("upd_hold_period", period_q, 32'd4);
    for (int i = 0; i < 40 && !m_wrap; i++) step();
    check("upd_new_period", period_q, 32'd2);
    steps(12);

    // Update coincident with a wrap tick.
    for (int i = 0; i < 40 && !(m_run && m_left == 1 && m_cnt == m_per); i++) step();
    check("wait_prewrap", CW'(m_left == 1 && m_cnt == m_per), CW'(1));
    on_count = 32'd7; update = 1'b1;
    step();
    update = 1'b0;
    check("coinc_wrap", CW'(wrap), CW'(1));
    check("coinc_on", on_count_q, 32'd7);
    on_count = 32'd9;
    steps(14);
    check("coinc_no_pending", on_count_q, 32'd7);

    // Stop mid-period at counter 2.
    period = 32'd4; update = 1'b1;
    step();
    update = 1'b0;
    for (int i = 0; i < 60 && !(m_strb && m_cnt == 2); i++) step();
    check("wait_cnt2", CW'(m_strb && m_cnt == 2), CW'(1));
    enable = 1'b0;
    step();
    check("stop_running", CW'(running), CW'(0));
    steps(6);

    // One-shot: prescale 0, period 3.
    oneshot = 1'b1; prescale = 16'd0; period = 32'd3; enable = 1'b1;
    steps(10);
    check("os_done", CW'(done), CW'(1));
    enable = 1'b0;
    steps(2);
    enable = 1'b1;
    steps(3);
    oneshot = 1'b0;
    enable = 1'b0;
    step();

    // Async reset mid-period.
    prescale = 16'd1; period = 32'd5; enable = 1'b1;
    steps(7);
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    compare_all();
    enable = 1'b0;
    #2;
    rstn = 1'b1;
    steps(4);
    enable = 1'b1;
    steps(6);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) enable = ~enable;
      update = ($urandom_range(9) == 0);
      if ($urandom_range(7) == 0) prescale = PW'($urandom_range(3));
      if ($urandom_range(7) == 0) period = CW'($urandom_range(6));
      if ($urandom_range(7) == 0) on_count = CW'($urandom);
      if ($urandom_range(15) == 0) oneshot = $urandom_range(1) != 0;
      step();
    end
    update = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
